idli_rctl_m: RTL and testbench

Register-file access controller for the nibble-serial idli datapath. The 8x16b general register file rotates one 4b slice per cycle. This block keeps the free-running nibble phase and accepts operand/destination requests through a valid/ready handshake. It aligns each request to a word boundary (phase 0) and drives the register file's two read selects and its write port for exactly one full rotation.

---
 rtl/idli_rctl_m.sv | 140 ++++++++++++++
 tb/tb_idli_rctl_m.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/idli_rctl_m.sv
// Register-file access controller: aligns operand/destination requests to the
// nibble phase and sequences one full rotation. Optional macro: IDLI_RCTL_ZERO_REG_EN.
module idli_rctl_m #(
  parameter int NUM_NIBBLES = 4
) (
  input  logic                           i_rctl_gck,
  input  logic                           i_rctl_rst_n,
  input  logic                           i_rctl_vld,
  output logic                           o_rctl_rdy,
  input  logic [2:0]                     i_rctl_lhs,
  input  logic [2:0]                     i_rctl_rhs,
  input  logic [2:0]                     i_rctl_dst,
  input  logic                           i_rctl_wr,
  input  logic                           i_rctl_flush,
  output logic [2:0]                     o_reg_lhs,
  output logic [2:0]                     o_reg_rhs,
  output logic [2:0]                     o_reg_wr,
  output logic                           o_reg_wr_en,
`ifdef IDLI_RCTL_ZERO_REG_EN
  output logic                           o_rctl_lhs_zero,
  output logic                           o_rctl_rhs_zero,
`endif
  output logic [$clog2(NUM_NIBBLES)-1:0] o_rctl_phase,
  output logic                           o_rctl_busy,
  output logic                           o_rctl_first,
  output logic                           o_rctl_last,
  output logic                           o_rctl_done
);

  // state  | meaning
  // IDLE   | no request held, ready to accept
  // WAIT   | request latched, waiting for the next phase 0 (flushable)
  // ACTIVE | driving the register file for one full rotation
  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACTIVE} state_t;

  localparam int PW = $clog2(NUM_NIBBLES);
  localparam logic [PW-1:0] PHASE_LAST = PW'(NUM_NIBBLES - 1);

  state_t        state_q, state_d;
  logic [PW-1:0] phase_q, phase_d;
  logic [2:0]    lat_lhs_q, lat_rhs_q, lat_dst_q;
  logic [2:0]    lat_lhs_d, lat_rhs_d, lat_dst_d;
  logic          lat_wr_q, lat_wr_d;
  logic          accept, active_d, wr_en_d;

  assign o_rctl_rdy   = (state_q == ST_IDLE) || ((state_q == ST_ACTIVE) && (phase_q == PHASE_LAST));
  assign o_rctl_phase = phase_q;

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q + PW'(1);
    accept    = i_rctl_vld && o_rctl_rdy;
    lat_lhs_d = lat_lhs_q;
    lat_rhs_d = lat_rhs_q;
    lat_dst_d = lat_dst_q;
    lat_wr_d  = lat_wr_q;
    if (accept) begin
      lat_lhs_d = i_rctl_lhs;
      lat_rhs_d = i_rctl_rhs;
      lat_dst_d = i_rctl_dst;
      lat_wr_d  = i_rctl_wr;
    end
    case (state_q)
      ST_IDLE: begin
        if (accept) state_d = (phase_q == PHASE_LAST) ? ST_ACTIVE : ST_WAIT;
      end
      ST_WAIT: begin
        if (i_rctl_flush)        state_d = ST_IDLE;
        else if (phase_d == '0)  state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        // Flush is ignored here so a word write is never left partial.
        if (phase_q == PHASE_LAST) state_d = accept ? ST_ACTIVE : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    active_d = (state_d == ST_ACTIVE);
`ifdef IDLI_RCTL_ZERO_REG_EN
    wr_en_d  = active_d && lat_wr_d && (lat_dst_d != 3'd0);
`else
    wr_en_d  = active_d && lat_wr_d;
`endif
  end

  always_ff @(posedge i_rctl_gck or negedge i_rctl_rst_n) begin
    if (!i_rctl_rst_n) begin
      state_q   <= ST_IDLE;
      phase_q   <= '0;
      lat_lhs_q <= '0;
      lat_rhs_q <= '0;
      lat_dst_q <= '0;
      lat_wr_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      lat_lhs_q <= lat_lhs_d;
      lat_rhs_q <= lat_rhs_d;
      lat_dst_q <= lat_dst_d;
      lat_wr_q  <= lat_wr_d;
    end
  end

  // Outputs are registered from next-state so they line up with the nibble they describe.
  always_ff @(posedge i_rctl_gck or negedge i_rctl_rst_n) begin
    if (!i_rctl_rst_n) begin
      o_reg_lhs    <= '0;
      o_reg_rhs    <= '0;
      o_reg_wr     <= '0;
      o_reg_wr_en  <= 1'b0;
      o_rctl_busy  <= 1'b0;
      o_rctl_first <= 1'b0;
      o_rctl_last  <= 1'b0;
      o_rctl_done  <= 1'b0;
    end else begin
      if (active_d) begin
        o_reg_lhs <= lat_lhs_d;
        o_reg_rhs <= lat_rhs_d;
        o_reg_wr  <= lat_dst_d;
      end
      o_reg_wr_en  <= wr_en_d;
      o_rctl_busy  <= active_d;
      o_rctl_first <= active_d && (phase_d == '0);
      o_rctl_last  <= active_d && (phase_d == PHASE_LAST);
      o_rctl_done  <= (state_q == ST_ACTIVE) && (phase_q == PHASE_LAST);
    end
  end

`ifdef IDLI_RCTL_ZERO_REG_EN
  always_ff @(posedge i_rctl_gck or negedge i_rctl_rst_n) begin
    if (!i_rctl_rst_n) begin
      o_rctl_lhs_zero <= 1'b0;
      o_rctl_rhs_zero <= 1'b0;
    end else begin
      o_rctl_lhs_zero <= active_d && (lat_lhs_d == 3'd0);
      o_rctl_rhs_zero <= active_d && (lat_rhs_d == 3'd0);
    end
  end
`endif

endmodule

// File: tb/tb_idli_rctl_m.sv
// Self-checking bench for idli_rctl_m: directed scenarios plus random traffic
// against a cycle-arithmetic reference model (handles IDLI_RCTL_ZERO_REG_EN).
module tb_idli_rctl_m;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vld, wr, flush;
  logic [2:0] lhs, rhs, dst;
  logic       rdy, reg_wr_en, busy, first, last, done;
  logic [2:0] reg_lhs, reg_rhs, reg_wr;
  logic [1:0] phase;
`ifdef IDLI_RCTL_ZERO_REG_EN
  logic       lhs_zero, rhs_zero;
`endif

  idli_rctl_m #(.NUM_NIBBLES(N)) dut (
    .i_rctl_gck(clk), .i_rctl_rst_n(rst_n),
    .i_rctl_vld(vld), .o_rctl_rdy(rdy),
    .i_rctl_lhs(lhs), .i_rctl_rhs(rhs), .i_rctl_dst(dst),
    .i_rctl_wr(wr), .i_rctl_flush(flush),
    .o_reg_lhs(reg_lhs), .o_reg_rhs(reg_rhs), .o_reg_wr(reg_wr), .o_reg_wr_en(reg_wr_en),
`ifdef IDLI_RCTL_ZERO_REG_EN
    .o_rctl_lhs_zero(lhs_zero), .o_rctl_rhs_zero(rhs_zero),
`endif
    .o_rctl_phase(phase), .o_rctl_busy(busy), .o_rctl_first(first),
    .o_rctl_last(last), .o_rctl_done(done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: operations are windows of N cycles starting at the
  // first phase-0 cycle after acceptance; k counts cycles since reset release.
  int         k;
  bit         cur_v, pend_v;
  int         cur_start, pend_start, done_at;
  logic [2:0] cur_l, cur_r, cur_d, pend_l, pend_r, pend_d;
  bit         cur_w, pend_w;
  logic       exp_rdy, exp_busy, exp_first, exp_last, exp_done, exp_wr_en;
  logic       exp_lz, exp_rz;
  logic [1:0] exp_phase;

  task automatic model_eval();
    if (pend_v && pend_start == k) begin
      cur_v = 1; cur_start = pend_start;
      cur_l = pend_l; cur_r = pend_r; cur_d = pend_d; cur_w = pend_w;
      pend_v = 0;
    end
    exp_phase = 2'(k % N);
    exp_busy  = cur_v && k >= cur_start && k < cur_start + N;
    exp_first = exp_busy && (k % N == 0);
    exp_last  = exp_busy && (k % N == N - 1);
    exp_done  = (done_at == k);
    exp_rdy   = !pend_v && (!exp_busy || (k % N == N - 1));
`ifdef IDLI_RCTL_ZERO_REG_EN
    exp_wr_en = exp_busy && cur_w && (cur_d != 3'd0);
`else
    exp_wr_en = exp_busy && cur_w;
`endif
    exp_lz = exp_busy && (cur_l == 3'd0);
    exp_rz = exp_busy && (cur_r == 3'd0);
  endtask

  task automatic model_reset();
    k = 0; cur_v = 0; pend_v = 0; cur_start = 0; pend_start = 0; done_at = -1;
    cur_l = 0; cur_r = 0; cur_d = 0; cur_w = 0;
    pend_l = 0; pend_r = 0; pend_d = 0; pend_w = 0;
    model_eval();
  endtask

  // Apply inputs for the current cycle, advance one clock, refresh expectations.
  task automatic step(input logic v, input logic [2:0] l, input logic [2:0] r,
                      input logic [2:0] d, input logic w, input logic f);
    vld = v; lhs = l; rhs = r; dst = d; wr = w; flush = f;
    if (exp_last) done_at = k + 1;
    if (v && exp_rdy) begin
      pend_v = 1; pend_start = k + N - (k % N);
      pend_l = l; pend_r = r; pend_d = d; pend_w = w;
    end else if (f && pend_v) begin
      pend_v = 0;
    end
    @(posedge clk); #1;
    k++;
    model_eval();
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic align(input int p);
    for (int i = 0; i < N && (k % N) != p; i++) idle();
  endtask

  task automatic test_reset();
    n_cmp++;
    if ({rdy, busy, first, last, done, reg_wr_en} !== {exp_rdy, exp_busy, exp_first, exp_last, exp_done, exp_wr_en}) begin
      n_err++; $display("FAIL reset_ctrl: got %b want %b", {rdy, busy, first, last, done, reg_wr_en},
                        {exp_rdy, exp_busy, exp_first, exp_last, exp_done, exp_wr_en});
    end
    n_cmp++;
    if ({phase, reg_lhs, reg_rhs, reg_wr} !== 11'd0) begin
      n_err++; $display("FAIL reset_regs: got %h want 0", {phase, reg_lhs, reg_rhs, reg_wr});
    end
  endtask

  task automatic test_basic();
    int start = -1, cnt = 0;
    align(0);
    step(1, 3'd1, 3'd2, 3'd3, 1, 0);
    n_cmp++;
    if (rdy !== 1'b0) begin n_err++; $display("FAIL basic_rdy_drop: got %b want 0", rdy); end
    for (int i = 1; i <= 10; i++) begin
      if (busy === 1'b1 && start < 0) start = i;
      if (busy === 1'b1) cnt++;
      n_cmp++;
      if ({busy, first, last, done, reg_wr_en, reg_wr} !== {exp_busy, exp_first, exp_last, exp_done, exp_wr_en, cur_d}) begin
        n_err++; $display("FAIL basic_cycle%0d: got %b want %b", i, {busy, first, last, done, reg_wr_en, reg_wr},
                          {exp_busy, exp_first, exp_last, exp_done, exp_wr_en, cur_d});
      end
      idle();
    end
    n_cmp++;
    if (start !== 4) begin n_err++; $display("FAIL basic_latency: got %0d want 4", start); end
    n_cmp++;
    if (cnt !== 4) begin n_err++; $display("FAIL basic_len: got %0d want 4", cnt); end
  endtask

  task automatic test_latency();
    int lat = 0;
    align(3);
    step(1, 3'd6, 3'd7, 3'd5, 1, 0);
    n_cmp++;
    if ({busy, first, reg_wr_en, reg_wr} !== {exp_busy, exp_first, exp_wr_en, 3'd5} || busy !== 1'b1) begin
      n_err++; $display("FAIL latency_p3: got %b want %b", {busy, first, reg_wr_en, reg_wr}, {exp_busy, exp_first, exp_wr_en, 3'd5});
    end
    repeat (N) idle();
    align(1);
    step(1, 3'd2, 3'd4, 3'd1, 0, 0);
    lat = 1;
    for (int i = 0; i < 8 && busy !== 1'b1; i++) begin
      n_cmp++;
      if (busy !== exp_busy) begin n_err++; $display("FAIL latency_wait: got %b want %b", busy, exp_busy); end
      idle(); lat++;
    end
    n_cmp++;
    if (lat !== 3) begin n_err++; $display("FAIL latency_p1: got %0d want 3", lat); end
    repeat (N + 1) idle();
  endtask

  task automatic test_back_to_back();
    logic [2:0] req_l [3] = '{3'd1, 3'd4, 3'd7};
    int issued = 0, cnt = 0, fb = -1, lb = -1;
    align(0);
    for (int i = 0; i < 20; i++) begin
      if (busy === 1'b1) begin cnt++; lb = i; if (fb < 0) fb = i; end
      n_cmp++;
      if ({rdy, busy, done, reg_lhs} !== {exp_rdy, exp_busy, exp_done, cur_l}) begin
        n_err++; $display("FAIL b2b_cycle%0d: got %b want %b", i, {rdy, busy, done, reg_lhs}, {exp_rdy, exp_busy, exp_done, cur_l});
      end
      if (issued < 3) begin
        if (exp_rdy) begin step(1, req_l[issued], 3'd2, 3'd3, 1, 0); issued++; end
        else step(1, req_l[issued], 3'd2, 3'd3, 1, 0);
      end else idle();
    end
    n_cmp++;
    if (cnt !== 12 || (lb - fb + 1) !== 12) begin
      n_err++; $display("FAIL b2b_contig: got %0d busy over %0d cycles want 12/12", cnt, lb - fb + 1);
    end
  endtask

  task automatic test_flush();
    int cnt = 0;
    align(1);
    step(1, 3'd1, 3'd1, 3'd2, 1, 0);
    step(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      n_cmp++;
      if ({reg_wr_en, busy, rdy} !== {exp_wr_en, exp_busy, exp_rdy} || reg_wr_en !== 1'b0) begin
        n_err++; $display("FAIL flush_wait%0d: got %b want %b", i, {reg_wr_en, busy, rdy}, {exp_wr_en, exp_busy, exp_rdy});
      end
      idle();
    end
    align(3);
    step(1, 3'd3, 3'd3, 3'd4, 1, 0);
    for (int i = 0; i < 8; i++) begin
      if (busy === 1'b1) cnt++;
      n_cmp++;
      if ({busy, reg_wr_en} !== {exp_busy, exp_wr_en}) begin
        n_err++; $display("FAIL flush_active%0d: got %b want %b", i, {busy, reg_wr_en}, {exp_busy, exp_wr_en});
      end
      step(0, 0, 0, 0, 0, 1);
    end
    n_cmp++;
    if (cnt !== 4) begin n_err++; $display("FAIL flush_active_len: got %0d want 4", cnt); end
  endtask

  task automatic test_async_reset();
    align(0);
    step(1, 3'd1, 3'd2, 3'd7, 1, 0);
    for (int i = 0; i < 10 && !(exp_busy && (k % N) == 2); i++) idle();
    n_cmp++;
    if (busy !== 1'b1 || phase !== 2'd2) begin
      n_err++; $display("FAIL areset_pre: got busy=%b phase=%0d want busy=1 phase=2", busy, phase);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({reg_wr_en, busy, phase} !== 4'b0000) begin
      n_err++; $display("FAIL areset_now: got %b want 0000", {reg_wr_en, busy, phase});
    end
    @(posedge clk); #1;
    rst_n = 1'b1; vld = 0; flush = 0;
    model_reset();
    n_cmp++;
    if (rdy !== exp_rdy || rdy !== 1'b1) begin n_err++; $display("FAIL areset_rdy: got %b want 1", rdy); end
    step(1, 3'd4, 3'd5, 3'd6, 1, 0);
    for (int i = 0; i < 10; i++) begin
      n_cmp++;
      if ({busy, reg_wr_en, reg_wr, phase} !== {exp_busy, exp_wr_en, cur_d, exp_phase}) begin
        n_err++; $display("FAIL areset_after%0d: got %b want %b", i, {busy, reg_wr_en, reg_wr, phase}, {exp_busy, exp_wr_en, cur_d, exp_phase});
      end
      idle();
    end
  endtask

  task automatic test_zero_reg();
    int wcnt = 0;
`ifdef IDLI_RCTL_ZERO_REG_EN
    int want = 0;
`else
    int want = 4;
`endif
    align(0);
    step(1, 3'd0, 3'd5, 3'd0, 1, 0);
    for (int i = 0; i < 8; i++) begin
      if (reg_wr_en === 1'b1) wcnt++;
      n_cmp++;
      if ({reg_wr_en, reg_wr, busy} !== {exp_wr_en, cur_d, exp_busy}) begin
        n_err++; $display("FAIL zero_wr%0d: got %b want %b", i, {reg_wr_en, reg_wr, busy}, {exp_wr_en, cur_d, exp_busy});
      end
`ifdef IDLI_RCTL_ZERO_REG_EN
      n_cmp++;
      if ({lhs_zero, rhs_zero} !== {exp_lz, exp_rz}) begin
        n_err++; $display("FAIL zero_flags%0d: got %b want %b", i, {lhs_zero, rhs_zero}, {exp_lz, exp_rz});
      end
`endif
      idle();
    end
    n_cmp++;
    if (wcnt !== want) begin n_err++; $display("FAIL zero_wr_count: got %0d want %0d", wcnt, want); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      n_cmp++;
      if ({rdy, busy, first, last, done, reg_wr_en, phase} !==
          {exp_rdy, exp_busy, exp_first, exp_last, exp_done, exp_wr_en, exp_phase}) begin
        n_err++; $display("FAIL rand_ctrl@%0d: got %b want %b", k, {rdy, busy, first, last, done, reg_wr_en, phase},
                          {exp_rdy, exp_busy, exp_first, exp_last, exp_done, exp_wr_en, exp_phase});
      end
      n_cmp++;
      if ({reg_lhs, reg_rhs, reg_wr} !== {cur_l, cur_r, cur_d}) begin
        n_err++; $display("FAIL rand_sel@%0d: got %h want %h", k, {reg_lhs, reg_rhs, reg_wr}, {cur_l, cur_r, cur_d});
      end
`ifdef IDLI_RCTL_ZERO_REG_EN
      n_cmp++;
      if ({lhs_zero, rhs_zero} !== {exp_lz, exp_rz}) begin
        n_err++; $display("FAIL rand_zero@%0d: got %b want %b", k, {lhs_zero, rhs_zero}, {exp_lz, exp_rz});
      end
`endif
      step(($urandom_range(0, 99) < 45), 3'($urandom), 3'($urandom), 3'($urandom),
           1'($urandom), ($urandom_range(0, 99) < 20));
    end
  endtask

  initial begin
    rst_n = 1'b0; vld = 0; wr = 0; flush = 0; lhs = 0; rhs = 0; dst = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    test_reset();
    test_basic();
    test_latency();
    test_back_to_back();
    test_flush();
    test_async_reset();
    test_zero_reg();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
